memory_read_arbiter_rr: RTL and testbench

Round-robin arbiter that shares one single-port read memory (instruction BRAM) among 2**PORT_ID_BITS engine/station requesters. Each cycle at most one request is granted with a same-cycle valid/ready handshake. The winner's address is driven to the memory. The returned word is broadcast to every requester, and a one-hot response strobe tells the winner its data is present. The block sits between the engine_and_station array and the shared instruction memory.

---
 rtl/memory_read_arbiter_rr.sv | 145 ++++++++++++++
 tb/tb_memory_read_arbiter_rr.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/memory_read_arbiter_rr.sv
// ---------------------------------------------------------------------------
// memory_read_arbiter_rr
//
// Round-robin arbiter that shares one single-port read memory among
// 2**PORT_ID_BITS requesters. At most one request is granted per cycle,
// through a same-cycle valid/ready handshake. The winner's address goes
// straight to the memory. The returned word is broadcast to all requesters,
// and a one-hot strobe marks the cycle in which the data belongs to the
// original winner.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-low reset; forces every control output
//              to zero while low
//   req_valid  per-requester read request (N bits)
//   req_addr   requester i address at [i*MEMORY_ADDR_WIDTH +: MEMORY_ADDR_WIDTH]
//   req_ready  one-hot grant; a handshake is req_valid[i] & req_ready[i]
//   rsp_valid  one-hot strobe; rsp_data belongs to requester i this cycle
//   rsp_data   broadcast read data, passed straight through from mem_data
//   mem_en     memory read enable
//   mem_addr   memory read address (0 when nothing is granted)
//   mem_data   memory read data, valid MEMORY_LATENCY cycles after mem_en
//   grant_id   index of the current winner (0 when nothing is granted)
//   busy       a read is granted this cycle or is still in flight
// ---------------------------------------------------------------------------
module memory_read_arbiter_rr #(
  parameter int PORT_ID_BITS      = 2,
  parameter int MEMORY_WIDTH      = 20,
  parameter int MEMORY_ADDR_WIDTH = 11,
  parameter int MEMORY_LATENCY    = 1    // legal range 1..8
) (
  input  logic                                            clk,
  input  logic                                            rst,
  input  logic [(2**PORT_ID_BITS)-1:0]                    req_valid,
  input  logic [(2**PORT_ID_BITS)*MEMORY_ADDR_WIDTH-1:0]  req_addr,
  output logic [(2**PORT_ID_BITS)-1:0]                    req_ready,
  output logic [(2**PORT_ID_BITS)-1:0]                    rsp_valid,
  output logic [MEMORY_WIDTH-1:0]                         rsp_data,
  output logic                                            mem_en,
  output logic [MEMORY_ADDR_WIDTH-1:0]                    mem_addr,
  input  logic [MEMORY_WIDTH-1:0]                         mem_data,
  output logic [PORT_ID_BITS-1:0]                         grant_id,
  output logic                                            busy
);

  localparam int N = 2**PORT_ID_BITS;

  // Rotating priority pointer: the search for a winner starts here.
  logic [PORT_ID_BITS-1:0] ptr_q, ptr_d;

  // Response tracking pipeline. Each stage holds {valid, requester id} for
  // one read in flight. The last stage lines up with valid mem_data.
  logic [MEMORY_LATENCY-1:0]                   stg_valid_q, stg_valid_d;
  logic [MEMORY_LATENCY-1:0][PORT_ID_BITS-1:0] stg_id_q,    stg_id_d;

  logic                    found;
  logic                    grant;
  logic [PORT_ID_BITS-1:0] win_id;
  logic [PORT_ID_BITS-1:0] cand;

  // Winner search: walk ptr, ptr+1, ... and stop at the first request.
  // The candidate index is PORT_ID_BITS wide, so the modulo-N wrap is free.
  // NOTE: every variable written here is given a default before the loop.
  // Without the defaults, a path that leaves a variable unassigned would
  // infer a latch.
  always_comb begin
    found  = 1'b0;
    win_id = '0;
    cand   = ptr_q;
    for (int k = 0; k < N; k++) begin
      cand = ptr_q + PORT_ID_BITS'(k);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        win_id = cand;
      end
    end
  end

  // A grant is suppressed while reset is held, so all request-side outputs
  // read zero asynchronously.
  assign grant = found & rst;

  always_comb begin
    req_ready = '0;
    mem_en    = 1'b0;
    mem_addr  = '0;
    grant_id  = '0;
    if (grant) begin
      req_ready[win_id] = 1'b1;
      mem_en            = 1'b1;
      mem_addr          = req_addr[int'(win_id)*MEMORY_ADDR_WIDTH +: MEMORY_ADDR_WIDTH];
      grant_id          = win_id;
    end
  end

  // After a grant, the port just served drops to lowest priority.
  always_comb begin
    ptr_d = ptr_q;
    if (grant) begin
      ptr_d = win_id + PORT_ID_BITS'(1);
    end
  end

  // Stage 0 captures this cycle's grant. Later stages shift by one per cycle.
  always_comb begin
    stg_valid_d    = stg_valid_q;
    stg_id_d       = stg_id_q;
    stg_valid_d[0] = mem_en;
    stg_id_d[0]    = grant_id;
    for (int s = 1; s < MEMORY_LATENCY; s++) begin
      stg_valid_d[s] = stg_valid_q[s-1];
      stg_id_d[s]    = stg_id_q[s-1];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only. All flops
  // then update together at the edge, with no dependence on evaluation order.
  // NOTE: the tracking pipeline is reset, not just the pointer. Clearing the
  // valid bits discards reads that were in flight when reset arrived, so no
  // stale strobe appears after release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q       <= '0;
      stg_valid_q <= '0;
      stg_id_q    <= '0;
    end else begin
      ptr_q       <= ptr_d;
      stg_valid_q <= stg_valid_d;
      stg_id_q    <= stg_id_d;
    end
  end

  always_comb begin
    rsp_valid = '0;
    if (rst && stg_valid_q[MEMORY_LATENCY-1]) begin
      rsp_valid[stg_id_q[MEMORY_LATENCY-1]] = 1'b1;
    end
  end

  // The data is not registered. Only the strobe says who owns it.
  assign rsp_data = mem_data;

  assign busy = rst & (mem_en | (|stg_valid_q));

endmodule

// File: tb/tb_memory_read_arbiter_rr.sv
// ---------------------------------------------------------------------------
// Testbench for memory_read_arbiter_rr. Three instances (memory latency 1, 2
// and 3) share clock and reset. Each has a small memory model that returns
// f_mem(addr) after the instance's latency.
// ---------------------------------------------------------------------------
module tb_memory_read_arbiter_rr;

  logic clk;
  logic rst;

  int n_vec = 0;
  int n_err = 0;

  // Latency-1 instance
  logic [3:0]       v1, rdy1, rspv1;
  logic [3:0][10:0] a1;
  logic [19:0]      rd1, md1;
  logic             en1, busy1;
  logic [10:0]      ma1;
  logic [1:0]       gid1;

  // Latency-2 instance
  logic [3:0]       v2, rdy2, rspv2;
  logic [3:0][10:0] a2;
  logic [19:0]      rd2, md2;
  logic             en2, busy2;
  logic [10:0]      ma2;
  logic [1:0]       gid2;

  // Latency-3 instance
  logic [3:0]       v3, rdy3, rspv3;
  logic [3:0][10:0] a3;
  logic [19:0]      rd3, md3;
  logic             en3, busy3;
  logic [10:0]      ma3;
  logic [1:0]       gid3;

  memory_read_arbiter_rr #(.PORT_ID_BITS(2), .MEMORY_WIDTH(20),
                           .MEMORY_ADDR_WIDTH(11), .MEMORY_LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .req_valid(v1), .req_addr(a1), .req_ready(rdy1),
    .rsp_valid(rspv1), .rsp_data(rd1), .mem_en(en1), .mem_addr(ma1),
    .mem_data(md1), .grant_id(gid1), .busy(busy1));

  memory_read_arbiter_rr #(.PORT_ID_BITS(2), .MEMORY_WIDTH(20),
                           .MEMORY_ADDR_WIDTH(11), .MEMORY_LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst), .req_valid(v2), .req_addr(a2), .req_ready(rdy2),
    .rsp_valid(rspv2), .rsp_data(rd2), .mem_en(en2), .mem_addr(ma2),
    .mem_data(md2), .grant_id(gid2), .busy(busy2));

  memory_read_arbiter_rr #(.PORT_ID_BITS(2), .MEMORY_WIDTH(20),
                           .MEMORY_ADDR_WIDTH(11), .MEMORY_LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .req_valid(v3), .req_addr(a3), .req_ready(rdy3),
    .rsp_valid(rspv3), .rsp_data(rd3), .mem_en(en3), .mem_addr(ma3),
    .mem_data(md3), .grant_id(gid3), .busy(busy3));

  function automatic logic [19:0] f_mem(input logic [10:0] a);
    return {a[8:0], a} ^ 20'h5A5A5;
  endfunction

  // Memory models, one per latency
  logic [19:0] m1_pipe;
  logic [19:0] m2_pipe [2];
  logic [19:0] m3_pipe [3];

  always @(posedge clk) begin
    m1_pipe    <= f_mem(ma1);
    m2_pipe[0] <= f_mem(ma2);
    m2_pipe[1] <= m2_pipe[0];
    m3_pipe[0] <= f_mem(ma3);
    m3_pipe[1] <= m3_pipe[0];
    m3_pipe[2] <= m3_pipe[1];
  end

  assign md1 = m1_pipe;
  assign md2 = m2_pipe[1];
  assign md3 = m3_pipe[2];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Inputs are driven 1 time unit after the rising edge and checked 3 units later.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [3:0] oh;
    rst = 1'b0;
    v1 = 4'hF; v2 = 4'hF; v3 = 4'hF;
    a1 = '0; a2 = '0; a3 = '0;
    a1[0] = 11'h7FF;
    #2;
    // While reset is held, requests must not produce any output.
    check("rst_ready",  rdy1,  0);
    check("rst_mem_en", en1,   0);
    check("rst_addr",   ma1,   0);
    check("rst_gid",    gid1,  0);
    check("rst_busy",   busy1, 0);
    check("rst_rspv",   rspv1, 0);
    check("rst_en_l2",  en2,   0);
    check("rst_busy_l3", busy3, 0);
    v1 = 0; v2 = 0; v3 = 0;
    #5 rst = 1'b1;

    // Single requester at latency 1
    next_cycle(); v1 = 4'b0100; a1[2] = 11'h02A; #3;
    check("single_ready", rdy1, 4'b0100);
    check("single_addr",  ma1,  11'h02A);
    check("single_en",    en1,  1);
    check("single_gid",   gid1, 2);
    check("single_busy",  busy1, 1);
    check("single_rspv0", rspv1, 0);

    // Wrap-around: ptr is 3, so 1001 grants 3 first, then 0.
    next_cycle(); v1 = 4'b1001; a1[3] = 11'h013; a1[0] = 11'h300; #3;
    check("single_rspv", rspv1, 4'b0100);
    check("single_data", rd1,   f_mem(11'h02A));
    check("wrap_gid3",   gid1,  3);
    check("wrap_rdy3",   rdy1,  4'b1000);
    next_cycle(); #3;
    check("wrap_gid0",   gid1,  0);
    check("wrap_rdy0",   rdy1,  4'b0001);
    check("wrap_rspv3",  rspv1, 4'b1000);
    check("wrap_data3",  rd1,   f_mem(11'h013));
    next_cycle(); v1 = 4'b1111; a1[1] = 11'h111; #3;
    check("wrap_ptr1",   gid1,  1);
    check("wrap_rspv0",  rspv1, 4'b0001);
    check("wrap_data0",  rd1,   f_mem(11'h300));
    next_cycle(); v1 = 4'b0000; #3;
    check("drain_rspv",  rspv1, 4'b0010);
    check("drain_data",  rd1,   f_mem(11'h111));
    check("drain_en",    en1,   0);
    check("drain_busy",  busy1, 1);

    // Idle for 5 cycles; the pointer must hold at 2.
    for (int i = 0; i < 5; i++) begin
      next_cycle(); #3;
      check("idle_en",   en1,   0);
      check("idle_busy", busy1, 0);
      check("idle_rspv", rspv1, 0);
    end
    next_cycle(); v1 = 4'b1111; #3;
    check("idle_ptr_held", gid1, 2);
    next_cycle(); v1 = 4'b0000;
    next_cycle();

    // Latency 3: grants to ports 1, 2, 1 on consecutive cycles
    next_cycle(); v3 = 4'b0010; a3[1] = 11'h011; #3;
    check("l3_gid_t0",  gid3,  1);
    check("l3_busy_t0", busy3, 1);
    next_cycle(); v3 = 4'b0100; a3[2] = 11'h022; #3;
    check("l3_gid_t1",  gid3,  2);
    check("l3_rspv_t1", rspv3, 0);
    check("l3_busy_t1", busy3, 1);
    next_cycle(); v3 = 4'b0010; a3[1] = 11'h033; #3;
    check("l3_gid_t2",  gid3,  1);
    check("l3_rdy_t2",  rdy3,  4'b0010);
    check("l3_rspv_t2", rspv3, 0);
    next_cycle(); v3 = 4'b0000; #3;
    check("l3_rspv_t3", rspv3, 4'b0010);
    check("l3_data_t3", rd3,   f_mem(11'h011));
    check("l3_busy_t3", busy3, 1);
    next_cycle(); #3;
    check("l3_rspv_t4", rspv3, 4'b0100);
    check("l3_data_t4", rd3,   f_mem(11'h022));
    check("l3_busy_t4", busy3, 1);
    next_cycle(); #3;
    check("l3_rspv_t5", rspv3, 4'b0010);
    check("l3_data_t5", rd3,   f_mem(11'h033));
    check("l3_busy_t5", busy3, 1);
    next_cycle(); #3;
    check("l3_rspv_t6", rspv3, 0);
    check("l3_busy_t6", busy3, 0);

    // Reset mid-operation at latency 2
    next_cycle(); v2 = 4'b0001; a2[0] = 11'h055; #3;
    check("l2_gid_pre", gid2, 0);
    check("l2_en_pre",  en2,  1);
    next_cycle(); v2 = 4'b0100; a2[2] = 11'h066; #3;
    check("l2_busy_pre", busy2, 1);
    check("l2_gid2_pre", gid2,  2);
    rst = 1'b0; #1;
    check("arst_ready", rdy2,  0);
    check("arst_en",    en2,   0);
    check("arst_addr",  ma2,   0);
    check("arst_gid",   gid2,  0);
    check("arst_busy",  busy2, 0);
    check("arst_rspv",  rspv2, 0);
    v2 = 4'b0000;
    next_cycle(); #3; rst = 1'b1;
    next_cycle(); #3;
    check("post_rst_rspv", rspv2, 0);
    check("post_rst_busy", busy2, 0);
    next_cycle(); v2 = 4'b0101; a2[0] = 11'h077; a2[2] = 11'h088; #3;
    check("post_rst_gid",  gid2,  0);
    check("post_rst_addr", ma2,   11'h077);
    check("post_rst_rspv2", rspv2, 0);
    next_cycle(); v2 = 4'b0000; #3;
    check("post_rst_rspv3", rspv2, 0);
    next_cycle(); #3;
    check("post_rst_rsp",  rspv2, 4'b0001);
    check("post_rst_data", rd2,   f_mem(11'h077));

    // All four requesting continuously from reset, latency 1
    for (int i = 0; i < 4; i++) a1[i] = 11'h100 + 11'(i);
    for (int k = 0; k < 8; k++) begin
      next_cycle(); v1 = 4'b1111; #3;
      check("rr_gid", gid1, k % 4);
      if (k >= 1) begin
        oh = 4'b0001 << ((k - 1) % 4);
        check("rr_rspv", rspv1, oh);
        check("rr_data", rd1,   f_mem(11'h100 + 11'((k - 1) % 4)));
      end
    end
    next_cycle(); v1 = 4'b0000; #3;
    check("rr_last_rspv", rspv1, 4'b1000);
    check("rr_last_data", rd1,   f_mem(11'h103));
    check("rr_last_en",   en1,   0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
